// File: rtl/srl_seq_if.sv
// srl_seq_if: handshake bundle for the sequential right shifter.
//   Request  : i_VALID / o_READY carrying i_INPUT, i_SHIFT_AMOUNT (and i_ARITH when
//              SRL_SEQ_ARITH_EN is defined).
//   Response : o_VALID / i_READY carrying o_RESULT.
// Signal names are seen from the shifter: i_* flow into it, o_* flow out of it.
// modport slave is the shifter side, modport master is the requester side.
interface srl_seq_if #(
    parameter int unsigned p_DATA_WIDTH = 4
);
    localparam int unsigned lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH);

    logic                        i_VALID;
    logic                        o_READY;
    logic [p_DATA_WIDTH-1:0]     i_INPUT;
    logic [lp_SFT_AMT_WIDTH-1:0] i_SHIFT_AMOUNT;
`ifdef SRL_SEQ_ARITH_EN
    logic                        i_ARITH;
`endif
    logic                        o_VALID;
    logic                        i_READY;
    logic [p_DATA_WIDTH-1:0]     o_RESULT;

    modport slave (
`ifdef SRL_SEQ_ARITH_EN
        input  i_ARITH,
`endif
        input  i_VALID,
        output o_READY,
        input  i_INPUT,
        input  i_SHIFT_AMOUNT,
        output o_VALID,
        input  i_READY,
        output o_RESULT
    );

    modport master (
`ifdef SRL_SEQ_ARITH_EN
        output i_ARITH,
`endif
        output i_VALID,
        input  o_READY,
        output i_INPUT,
        output i_SHIFT_AMOUNT,
        input  o_VALID,
        output i_READY,
        input  o_RESULT
    );
endinterface

// File: rtl/srl_seq.sv
// srl_seq: sequential right shifter, one bit position per clock.
//   i_CLK   : clock, rising edge active.
//   i_RST_N : asynchronous active-low reset.
//   bus     : srl_seq_if.slave; accepts a word + amount on i_VALID/o_READY and
//             presents the shifted word on o_VALID/i_READY via o_RESULT.
// Optional feature macro SRL_SEQ_ARITH_EN: adds i_ARITH; when set at acceptance the
// vacated bits are filled with the input sign bit, otherwise zero fill.
// o_READY / o_VALID are registered alongside the state, so there is no combinational
// path from any input to any output.
module srl_seq #(
    parameter int unsigned p_DATA_WIDTH = 4
) (
    input  logic      i_CLK,
    input  logic      i_RST_N,
    srl_seq_if.slave  bus
);
    localparam int unsigned lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH);
    localparam logic [lp_SFT_AMT_WIDTH-1:0] lp_CNT_ONE = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                      state_q;
    logic [p_DATA_WIDTH-1:0]     data_q;
    logic [lp_SFT_AMT_WIDTH-1:0] cnt_q;
    logic                        fill_q;
    logic                        ready_q;
    logic                        valid_q;
    logic                        fill_in;

`ifdef SRL_SEQ_ARITH_EN
    assign fill_in = bus.i_ARITH & bus.i_INPUT[p_DATA_WIDTH-1];
`else
    assign fill_in = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_VALID) begin
                        data_q  <= bus.i_INPUT;
                        cnt_q   <= bus.i_SHIFT_AMOUNT;
                        fill_q  <= fill_in;
                        ready_q <= 1'b0;
                        // Zero shift goes straight to DONE: result valid one cycle later.
                        if (bus.i_SHIFT_AMOUNT == '0) begin
                            state_q <= StDone;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    data_q <= {fill_q, data_q[p_DATA_WIDTH-1:1]};
                    cnt_q  <= cnt_q - lp_CNT_ONE;
                    if (cnt_q == lp_CNT_ONE) begin
                        state_q <= StDone;
                        valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    // data_q is left untouched so the last result stays visible.
                    if (bus.i_READY) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_READY  = ready_q;
    assign bus.o_VALID  = valid_q;
    assign bus.o_RESULT = data_q;

endmodule

// File: tb/tb_srl_seq.sv
// tb_srl_seq: directed bench for srl_seq at 8-bit width. Stimulus pushes expected
// results into a queue; a monitor pops and compares on every result handshake.
module tb_srl_seq;
    logic clk;
    logic rst_n;

    srl_seq_if #(.p_DATA_WIDTH(8)) bus ();

    srl_seq #(.p_DATA_WIDTH(8)) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a result is delivered when o_VALID && i_READY ahead of the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.o_VALID && bus.i_READY) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0h expected none", bus.o_RESULT);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("result", {24'd0, bus.o_RESULT}, {24'd0, e});
            end
        end
    end

    // Present a request for one edge (caller is at posedge+2), then scramble the inputs.
    task automatic issue(input logic [7:0] d, input logic [2:0] k, input logic ar);
        chk("ready_before_issue", {31'd0, bus.o_READY}, 32'd1);
        bus.i_VALID        = 1'b1;
        bus.i_INPUT        = d;
        bus.i_SHIFT_AMOUNT = k;
`ifdef SRL_SEQ_ARITH_EN
        bus.i_ARITH        = ar;
`else
        if (ar) $display("note: arith request ignored in logical build");
`endif
        @(posedge clk);
        #2;
        bus.i_VALID        = 1'b0;
        bus.i_INPUT        = d ^ 8'hA5;
        bus.i_SHIFT_AMOUNT = ~k;
`ifdef SRL_SEQ_ARITH_EN
        bus.i_ARITH        = ~ar;
`endif
    endtask

    // Count edges after acceptance until o_VALID; must equal the shift amount.
    task automatic wait_valid(input int k, input string name);
        int n = 0;
        while (!bus.o_VALID && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({name, "_latency"}, n, k);
        chk({name, "_ready_low"}, {31'd0, bus.o_READY}, 32'd0);
    endtask

    task automatic op(input logic [7:0] d, input logic [2:0] k, input logic ar,
                      input logic [7:0] exp, input string name);
        exp_q.push_back(exp);
        issue(d, k, ar);
        wait_valid(int'(k), name);
        @(posedge clk);
        #2;
        chk({name, "_ready_after"}, {31'd0, bus.o_READY}, 32'd1);
        chk({name, "_valid_after"}, {31'd0, bus.o_VALID}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n              = 1'b0;
        bus.i_VALID        = 1'b0;
        bus.i_INPUT        = 8'h00;
        bus.i_SHIFT_AMOUNT = 3'd0;
        bus.i_READY        = 1'b1;
`ifdef SRL_SEQ_ARITH_EN
        bus.i_ARITH        = 1'b0;
`endif
        #12;
        chk("reset_ready",  {31'd0, bus.o_READY}, 32'd1);
        chk("reset_valid",  {31'd0, bus.o_VALID}, 32'd0);
        chk("reset_result", {24'd0, bus.o_RESULT}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        op(8'hB4, 3'd3, 1'b0, 8'h16, "basic");
        op(8'h5A, 3'd0, 1'b0, 8'h5A, "zero");
        op(8'h80, 3'd7, 1'b0, 8'h01, "max");
        op(8'hFF, 3'd4, 1'b0, 8'h0F, "ones");

        // Backpressure: hold DONE, pulse new requests that must be ignored.
        bus.i_READY = 1'b0;
        exp_q.push_back(8'h0F);
        issue(8'h3C, 3'd2, 1'b0);
        wait_valid(2, "bp");
        for (int i = 0; i < 5; i++) begin
            bus.i_VALID        = i[0];
            bus.i_INPUT        = 8'hAA;
            bus.i_SHIFT_AMOUNT = 3'd1;
            @(negedge clk);
            chk("bp_result_stable", {24'd0, bus.o_RESULT}, 32'h0F);
            chk("bp_ready_low", {31'd0, bus.o_READY}, 32'd0);
            chk("bp_valid_held", {31'd0, bus.o_VALID}, 32'd1);
            @(posedge clk);
            #2;
        end
        bus.i_VALID = 1'b1;
        bus.i_READY = 1'b1;
        @(posedge clk);
        #2;
        // Handshake edge must not double as an accept edge.
        chk("bp_no_overlap_ready", {31'd0, bus.o_READY}, 32'd1);
        chk("bp_no_overlap_valid", {31'd0, bus.o_VALID}, 32'd0);
        exp_q.push_back(8'h55);
        @(posedge clk);
        #2;
        bus.i_VALID = 1'b0;
        wait_valid(1, "bp_next");
        @(posedge clk);
        #2;
        chk("bp_next_ready", {31'd0, bus.o_READY}, 32'd1);

        // Reset in the middle of a shift: nothing must come out.
        issue(8'hFF, 3'd6, 1'b0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",  {31'd0, bus.o_VALID}, 32'd0);
        chk("rst_mid_result", {24'd0, bus.o_RESULT}, 32'd0);
        chk("rst_mid_ready",  {31'd0, bus.o_READY}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= bus.o_VALID;
        end
        chk("rst_no_result", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #2;

        op(8'hC3, 3'd1, 1'b0, 8'h61, "after_reset");

`ifdef SRL_SEQ_ARITH_EN
        op(8'hB4, 3'd3, 1'b1, 8'hF6, "arith_neg");
        op(8'hB4, 3'd3, 1'b0, 8'h16, "arith_off");
        op(8'h34, 3'd2, 1'b1, 8'h0D, "arith_pos");
`endif

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/srl_seq.md
# srl_seq

Sequential logical right shifter for the arithmetic/shifter library. It is the right-direction counterpart to the combinational left shifter.
- Accepts one word and a shift amount through a valid/ready handshake.
- Shifts the word right by one bit per clock.
- Presents the result under a second valid/ready handshake.

It targets area-constrained paths where a full barrel shifter is too costly.

## Interface
- p_DATA_WIDTH, 4: word width; minimum 2; a power of two is recommended.
- lp_SFT_AMT_WIDTH (local), $clog2(p_DATA_WIDTH): shift amount width; maximum shift is p_DATA_WIDTH-1.

Clock is i_CLK; reset is i_RST_N, asynchronous and active-low.
- i_CLK  in  1  clock; all state changes on the rising edge.
- i_RST_N  in  1  asynchronous active-low reset.
- i_VALID  in  1  input word and amount valid.
- o_READY  out  1  block idle and able to accept.
- i_INPUT  in  p_DATA_WIDTH  word to shift.
- i_SHIFT_AMOUNT  in  lp_SFT_AMT_WIDTH  number of bit positions to shift right.
- i_ARITH  in  1  sign-fill select; present only when SRL_SEQ_ARITH_EN is defined.
- o_VALID  out  1  result valid.
- i_READY  in  1  downstream accepts the result.
- o_RESULT  out  p_DATA_WIDTH  shifted word; registered.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers: data register (drives o_RESULT), down-counter cnt (lp_SFT_AMT_WIDTH bits), fill bit.
- o_READY = (state == IDLE). o_VALID = (state == DONE). Both are decoded from state only, with no combinational input-to-output path.
- IDLE:
  - Acceptance is i_VALID && o_READY at an edge.
  - On acceptance: data <= i_INPUT, cnt <= i_SHIFT_AMOUNT, fill bit captured.
  - Next state is DONE if i_SHIFT_AMOUNT == 0, otherwise SHIFT.
- SHIFT:
  - Each edge: data <= {fill, data[p_DATA_WIDTH-1:1]}, cnt <= cnt-1.
  - When cnt == 1 at the edge, the last shift occurs and state <= DONE.
- DONE:
  - o_RESULT is held stable.
  - When i_READY is high at an edge, state <= IDLE. The data register keeps its value.
- Inputs are sampled only at acceptance. Changes on i_INPUT, i_SHIFT_AMOUNT or i_ARITH afterwards are ignored.
- i_VALID is ignored in SHIFT and DONE. Accept and deliver never overlap: a new word can be accepted no earlier than the edge after the result handshake.
- Result equals i_INPUT >> i_SHIFT_AMOUNT (zero fill), or the sign-filled equivalent when arithmetic mode is enabled and selected.

## Timing
- Reset values (asynchronous, held while i_RST_N is low): state IDLE, data 0, cnt 0, fill 0.
  - Outputs: o_RESULT = 0, o_VALID = 0, o_READY = 1.
- Latency: for shift amount k accepted at edge e0, o_VALID rises after edge e_k (the e0 edge itself when k = 0).
  - This is k+1 cycles from the accept cycle, with a minimum of 1.
  - Worst case is p_DATA_WIDTH cycles.
- Throughput: one word per k+2 cycles with i_READY held high.
- Backpressure: with i_READY low, DONE persists indefinitely and o_RESULT stays stable.
- Reset mid-operation (SHIFT or DONE): the operation is aborted, no result is delivered, and all registers return to reset values immediately.

## Configuration
- SRL_SEQ_ARITH_EN:
  - Defined: port i_ARITH exists. At acceptance, fill <= i_ARITH & i_INPUT[p_DATA_WIDTH-1], giving an arithmetic shift when i_ARITH = 1 and a logical shift when 0.
  - Undefined: no i_ARITH port and fill is constant 0, giving a pure logical shift.

## Test plan
All cases use p_DATA_WIDTH = 8.
- Basic: accept 0xB4, amount 3, i_READY = 1 → o_VALID high 4 cycles after the accept cycle, o_RESULT = 0x16, then o_READY = 1 on the next cycle.
- Zero shift: accept 0x5A, amount 0 → o_VALID in the cycle after acceptance, o_RESULT = 0x5A.
- Maximum shift: accept 0x80, amount 7 → o_VALID after 8 cycles, o_RESULT = 0x01.
- Backpressure and ignored inputs:
  - Hold i_READY low 5 cycles in DONE while pulsing i_VALID with new data.
  - Required: o_RESULT stable, o_READY = 0, and no second acceptance until the cycle after the i_READY handshake.
- Reset mid-shift: assert i_RST_N low during SHIFT of 0xFF, amount 6 → o_VALID = 0, o_RESULT = 0 and o_READY = 1 immediately; no result appears after reset release.
- Arithmetic (SRL_SEQ_ARITH_EN defined):
  - 0xB4, amount 3, i_ARITH = 1 → 0xF6.
  - Same input with i_ARITH = 0 → 0x16.
  - 0x34, amount 2, i_ARITH = 1 → 0x0D.
